// File: rtl/spi_reg_responder.sv
// SPI peripheral terminating address+data frames into a small register bank.
// All SPI pins are oversampled on clk; the bank is written at end of frame.
module spi_reg_responder #(
    parameter int REG_WIDTH = 8,
    parameter int MSG_LEN = 2,
    parameter int NUM_REGS = 16,
    localparam int DATA_WIDTH = REG_WIDTH * (MSG_LEN - 1)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sclk,
    input  logic                           csn,
    input  logic                           mosi,
    output logic                           miso,
    output logic [DATA_WIDTH*NUM_REGS-1:0] reg_values,
    output logic                           write_strobe,
    output logic [REG_WIDTH-1:0]           write_addr,
    output logic [DATA_WIDTH-1:0]          write_data_out,
    output logic                           frame_error
);

    localparam int MAXW = (DATA_WIDTH > REG_WIDTH) ? DATA_WIDTH : REG_WIDTH;
    localparam int CW = $clog2(MAXW + 1);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(REG_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [REG_WIDTH-1:0] REG_LIMIT = REG_WIDTH'(NUM_REGS);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] COMMIT  = 3'd3;
    localparam logic [2:0] WAIT_CS = 3'd4;

    logic                  sclk_s1, sclk_s2, sclk_s3;
    logic                  csn_s1, csn_s2;
    logic                  mosi_s1, mosi_s2;
    logic [2:0]            state;
    logic                  armed;
    logic [CW-1:0]         cnt;
    logic [REG_WIDTH-1:0]  addr_sh;
    logic [REG_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  sclk_rise;
    logic                  sclk_fall;
    logic [REG_WIDTH-1:0]  addr_nxt;
    logic                  addr_nxt_ok;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] rx_nxt;
    logic [DATA_WIDTH-1:0] rd_val;

    assign sclk_rise   = sclk_s2 & ~sclk_s3;
    assign sclk_fall   = ~sclk_s2 & sclk_s3;
    assign addr_nxt    = {addr_sh[REG_WIDTH-2:0], mosi_s2};
    assign addr_nxt_ok = addr_nxt < REG_LIMIT;
    assign addr_ok     = addr < REG_LIMIT;
    assign rx_nxt      = {rx_sh[DATA_WIDTH-2:0], mosi_s2};
    assign rd_val      = addr_nxt_ok ? regs[addr_nxt[IW-1:0]] : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_values[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {sclk_s1, sclk_s2, sclk_s3} <= '0;
            {csn_s1, csn_s2}            <= '0;
            {mosi_s1, mosi_s2}          <= '0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            csn_s1  <= csn;
            csn_s2  <= csn_s1;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // A frame only starts after csn has been seen high, so the reset
    // value of the csn synchronizer cannot open a bogus frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            armed          <= 1'b0;
            cnt            <= '0;
            addr_sh        <= '0;
            addr           <= '0;
            rx_sh          <= '0;
            tx_sh          <= '0;
            miso           <= 1'b0;
            write_strobe   <= 1'b0;
            write_addr     <= '0;
            write_data_out <= '0;
            frame_error    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            write_strobe <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    cnt  <= '0;
                    if (csn_s2) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed   <= 1'b0;
                        addr_sh <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (csn_s2) begin
                        frame_error <= 1'b1;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        addr_sh <= addr_nxt;
                        if (cnt == ADDR_LAST) begin
                            addr  <= addr_nxt;
                            tx_sh <= rd_val;
                            miso  <= rd_val[DATA_WIDTH-1];
                            rx_sh <= '0;
                            cnt   <= '0;
                            state <= DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    // The final rise beats a simultaneous csn release.
                    if (sclk_rise && cnt == DATA_LAST) begin
                        rx_sh <= rx_nxt;
                        miso  <= 1'b0;
                        state <= COMMIT;
                    end else if (csn_s2) begin
                        frame_error <= 1'b1;
                        miso        <= 1'b0;
                        state       <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sh <= rx_nxt;
                        cnt   <= cnt + 1'b1;
                    end else if (sclk_fall && cnt != '0) begin
                        // Fall trailing the last address bit is skipped.
                        tx_sh <= tx_sh << 1;
                        miso  <= tx_sh[DATA_WIDTH-2];
                    end
                end
                COMMIT: begin
                    if (addr_ok) begin
                        regs[addr[IW-1:0]] <= rx_sh;
                        write_strobe       <= 1'b1;
                    end
                    write_addr     <= addr;
                    write_data_out <= rx_sh;
                    cnt            <= '0;
                    state          <= WAIT_CS;
                end
                WAIT_CS: begin
                    miso <= 1'b0;
                    if (csn_s2) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Bench for spi_reg_responder: directed and random frames driven as an
// SPI initiator at clk/8, checked against a register-array reference model.
module tb_spi_reg_responder;

    localparam int RW = 8;
    localparam int DW = 8;
    localparam int NR = 16;
    localparam int FW = DW * NR;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sclk;
    logic          csn;
    logic          mosi;
    logic          miso;
    logic [FW-1:0] reg_values;
    logic          write_strobe;
    logic [RW-1:0] write_addr;
    logic [DW-1:0] write_data_out;
    logic          frame_error;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;

    logic [DW-1:0] exp_regs [NR];
    logic [RW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;

    always #5 clk = ~clk;

    spi_reg_responder #(
        .REG_WIDTH(RW),
        .MSG_LEN  (2),
        .NUM_REGS (NR)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sclk          (sclk),
        .csn           (csn),
        .mosi          (mosi),
        .miso          (miso),
        .reg_values    (reg_values),
        .write_strobe  (write_strobe),
        .write_addr    (write_addr),
        .write_data_out(write_data_out),
        .frame_error   (frame_error)
    );

    always @(negedge clk) begin
        if (write_strobe === 1'b1) strobe_cnt++;
        if (frame_error === 1'b1) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [FW-1:0] got,
                         input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = exp_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        exp_wa = '0;
        exp_wd = '0;
    endtask

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        repeat (4) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic start_frame(input logic [RW-1:0] a);
        logic m;
        csn = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = RW - 1; i >= 0; i--) send_bit(a[i], m);
    endtask

    task automatic run_frame(input logic [RW-1:0] a, input logic [DW-1:0] d,
                             input int dbits, input int extra);
        int sc0;
        int ec0;
        logic m;
        logic [DW-1:0] cap;
        logic [DW-1:0] exp_miso;
        bit in_rng;
        bit complete;
        sc0 = strobe_cnt;
        ec0 = ferr_cnt;
        in_rng = a < NR;
        complete = (dbits == DW);
        exp_miso = in_rng ? exp_regs[a[3:0]] : '0;
        cap = '0;
        start_frame(a);
        for (int i = 0; i < dbits; i++) begin
            send_bit(d[DW-1-i], m);
            cap = {cap[DW-2:0], m};
        end
        for (int i = 0; i < extra; i++) send_bit(1'($urandom), m);
        repeat (4) @(negedge clk);
        csn = 1'b1;
        repeat (8) @(negedge clk);
        if (complete) begin
            if (in_rng) exp_regs[a[3:0]] = d;
            exp_wa = a;
            exp_wd = d;
            check($sformatf("miso_rd@%0h", a), FW'(cap), FW'(exp_miso));
        end
        check($sformatf("strobes@%0h", a), FW'(strobe_cnt - sc0),
              FW'((complete && in_rng) ? 1 : 0));
        check($sformatf("frame_err@%0h", a), FW'(ferr_cnt - ec0),
              FW'(complete ? extra : 1));
        check($sformatf("write_addr@%0h", a), FW'(write_addr), FW'(exp_wa));
        check($sformatf("write_data@%0h", a), FW'(write_data_out), FW'(exp_wd));
        check($sformatf("reg_values@%0h", a), reg_values, exp_flat());
        check($sformatf("miso_idle@%0h", a), FW'(miso), '0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_miso"}, FW'(miso), '0);
        check({pfx, "_strobe"}, FW'(write_strobe), '0);
        check({pfx, "_ferr"}, FW'(frame_error), '0);
        check({pfx, "_waddr"}, FW'(write_addr), '0);
        check({pfx, "_wdata"}, FW'(write_data_out), '0);
        check({pfx, "_regs"}, reg_values, exp_flat());
    endtask

    initial begin
        logic [RW-1:0] ra;
        logic [DW-1:0] rd;
        int rbits;
        int rextra;
        int ec0;
        logic m;

        model_reset();
        rstn = 1'b0;
        csn  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rstn = 1'b1;
        repeat (8) @(negedge clk);

        // sclk activity with csn high must be ignored
        ec0 = ferr_cnt;
        for (int i = 0; i < 3; i++) send_bit(1'b1, m);
        repeat (6) @(negedge clk);
        check("idle_sclk_ferr", FW'(ferr_cnt - ec0), '0);
        check("idle_sclk_regs", reg_values, exp_flat());

        run_frame(8'h03, 8'hA5, DW, 0);
        run_frame(8'h03, 8'h5A, DW, 0);
        run_frame(8'h20, 8'hFF, DW, 0);
        run_frame(8'h01, 8'hC3, 5, 0);
        run_frame(8'h01, 8'h11, DW, 0);
        run_frame(8'h02, 8'h7E, DW, 1);
        run_frame(8'h0F, 8'h81, DW, 0);
        run_frame(8'h10, 8'h42, DW, 0);

        // reset in the middle of the data phase
        start_frame(8'h04);
        for (int i = 0; i < 3; i++) send_bit(1'b1, m);
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_rst");
        csn = 1'b1;
        ec0 = ferr_cnt;
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_ferr", FW'(ferr_cnt - ec0), '0);
        run_frame(8'h04, 8'h3C, DW, 0);
        run_frame(8'h04, 8'h99, DW, 0);

        for (int k = 0; k < 20; k++) begin
            ra = RW'($urandom_range(0, 31));
            rd = DW'($urandom);
            rbits = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DW - 1) : DW;
            rextra = (rbits == DW && $urandom_range(0, 3) == 0) ? 1 : 0;
            run_frame(ra, rd, rbits, rextra);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI peripheral that terminates the frames issued by our SPI initiator.
- Frame format: REG_WIDTH-bit register address, then DATA_WIDTH data bits, MSB first on mosi. During the data phase it shifts the addressed register's previous contents out on miso.
- Holds a small register bank that is written at end of frame. The bank drives board control outputs and is instantiated in FPGA test firmware and benches as the far end of the SPI link.
- Runs entirely on the system clock. sclk, csn and mosi are oversampled.

Parameters:
- REG_WIDTH, 8: address field width in bits.
- MSG_LEN, 2: frame length in REG_WIDTH words. DATA_WIDTH = REG_WIDTH*(MSG_LEN-1).
- NUM_REGS, 16: number of implemented registers, at addresses 0..NUM_REGS-1.

Ports:
- clk, input, 1: system clock. Must be at least 4x the sclk frequency.
- rstn, input, 1: asynchronous active-low reset.
- sclk, input, 1: SPI serial clock, idle low, asynchronous to clk.
- csn, input, 1: active-low frame select, asynchronous to clk.
- mosi, input, 1: serial data from the initiator.
- miso, output, 1: serial data to the initiator.
- reg_values, output, DATA_WIDTH*NUM_REGS: flattened register bank. Register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- write_strobe, output, 1: one-clk pulse when a register is written.
- write_addr, output, REG_WIDTH: address of the last completed frame.
- write_data_out, output, DATA_WIDTH: data of the last completed frame.
- frame_error, output, 1: one-clk pulse on a malformed frame.

Behaviour:
- Reset: asynchronous on rstn low. Clears all of the following to 0:
  - every register and reg_values
  - miso, write_strobe, write_addr, write_data_out, frame_error
  - shift registers, bit counter and synchronizers
  - state returns to IDLE
- Reset mid-frame aborts the frame with no write.
- Synchronization: sclk, csn and mosi each pass through a 2-FF synchronizer. Edge detection uses the synchronized sclk against a third registered copy, so a pin edge becomes an internal event 3 clk later.
  - mosi is sampled when a synchronized sclk rising edge is detected.
- State machine: IDLE, ADDR, DATA, COMMIT, WAIT_CS.
- IDLE: miso=0, bit counter=0.
  - Synchronized csn low -> ADDR.
  - sclk edges seen while csn is high are ignored.
- ADDR:
  - Each sclk rise shifts mosi into the address shift register, LSB end, and increments the counter.
  - On the REG_WIDTH-th rise: latch the address; load the tx shifter with reg[addr], or with 0 if addr >= NUM_REGS; counter=0; go to DATA.
  - miso shows the tx MSB on the next clk.
- DATA:
  - Each sclk rise shifts mosi into the rx shifter.
  - Each sclk fall shifts the tx shifter left, so miso advances one bit per falling edge.
  - On the DATA_WIDTH-th rise -> COMMIT.
- COMMIT, exactly one clk:
  - If addr < NUM_REGS: reg[addr] <= rx data, and write_strobe=1 for this clk.
  - If addr is out of range: no write and no strobe.
  - In both cases write_addr/write_data_out are updated.
  - Go to WAIT_CS.
  - reg_values reflects the new value 1 clk after the strobe.
- WAIT_CS: miso=0.
  - csn high -> IDLE.
  - Any sclk rise here -> frame_error pulse, and the extra bits are ignored.
  - Additional edges in this state each pulse frame_error again.
- Abort: csn goes high in ADDR or DATA -> frame_error pulse, no write, registers unchanged, go to IDLE.
- Simultaneous events:
  - If csn-high and the final sclk rise are detected in the same clk, the rise wins: COMMIT proceeds, then WAIT_CS sees csn high and returns to IDLE.
  - A csn falling edge while in WAIT_CS never occurs without a preceding high. A new frame requires csn high for at least 1 synchronized clk.
- miso is never tri-stated. It is 0 outside the DATA state.
- Counters are sized for DATA_WIDTH+1 and never wrap within a legal frame.

Test Plan:
- Write frame: addr 0x03, data 0xA5, with sclk = clk/8.
  - Required: write_strobe pulses once with write_addr=0x03 and write_data_out=0xA5.
  - Required: reg_values[31:24]=0xA5, and miso returned 0x00 (prior contents).
- Read-back: addr 0x03, data 0x5A, sent after the write frame.
  - Required: miso bits captured on sclk rises = 0xA5.
  - Required: reg 3 = 0x5A.
- Out-of-range: addr 0x20, data 0xFF.
  - Required: miso returns 0x00, no write_strobe, no reg_values change, write_addr=0x20.
- Abort: csn raised after 5 data bits of addr 0x01, data 0xC3.
  - Required: one frame_error pulse, reg 1 unchanged, next frame (addr 0x01, data 0x11) writes correctly.
- Overrun: 17 sclk pulses in one frame (addr 0x02, data 0x7E, then an extra pulse).
  - Required: reg 2 = 0x7E, exactly one frame_error pulse.
- Reset mid-DATA: rstn low for 2 clk after 3 data bits.
  - Required: all outputs 0, state IDLE, the following full frame succeeds.
